dm_lsu: RTL and testbench
=========================

# dm_lsu

Load/store unit with a private data memory, directly downstream of the ALU in the CPU datapath. It takes the ALU result as a byte address and the rs2 value as store data. It performs byte, halfword and word loads and stores with byte-lane steering and sign/zero extension. It answers the core through a valid/ready request and a one-cycle response pulse. The core stalls on `req_ready`/`rsp_valid`, which gives the datapath a real multi-cycle memory stage.

## Interface
- `ADDR_WIDTH`, 7, word-address bits; memory holds 2^ADDR_WIDTH 32-bit words.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present; held by the core until accepted.
- `req_ready` out 1: unit can accept; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data; byte stores use [7:0], half stores use [15:0].
- `rsp_valid` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load data, valid with `rsp_valid`; 0 for stores.
- `rsp_err` out 1: misaligned-access flag, valid with `rsp_valid`.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - LD_ACC: RAM read in flight.
  - RESP: `rsp_valid`=1.
- Transitions:
  - IDLE → LD_ACC on an accepted load.
  - IDLE → RESP on an accepted store or an erroring access.
  - LD_ACC → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Request fields `size`, `unsigned` and `addr[1:0]` are captured at acceptance. Later input changes do not affect the transaction.
- Word index is `addr[ADDR_WIDTH+1:2]`. Higher address bits are ignored, so addresses wrap modulo 4·2^ADDR_WIDTH bytes.
- Stores perform a byte-enabled write on the accepting edge:
  - Byte: lane `addr[1:0]`.
  - Half: lanes {1,0} if `addr[1]`=0, otherwise {3,2}.
  - Word: all four lanes.
  - Unselected lanes are unchanged.
- Loads register the full word in LD_ACC. In RESP they select the lane(s) by the captured offset and extend to 32 bits per `req_unsigned`. Words are never extended.
- Memory contents are not reset; only control state and outputs are.
- `req_valid` while not in IDLE is ignored (not accepted); no queueing.
- There is no response backpressure: `rsp_valid` is a single-cycle pulse and the core must sample it.

## Timing
- Reset values: `req_ready`=1 after reset (state IDLE), `rsp_valid`=0, `rdata`=0, `rsp_err`=0.
- Store latency: accepted at edge N, memory updated at edge N, `rsp_valid` high during cycle N+1. The next request can be accepted at edge N+2.
- Load latency: accepted at edge N, `rsp_valid`/`rdata` high during cycle N+2. The next acceptance is at edge N+3.
- A load to the same word as a store that completed earlier returns the stored data; there is no hazard because the unit is not pipelined.
- `rdata` and `rsp_err` hold their last value outside `rsp_valid` cycles. They are cleared only by reset.
- `rstn` low at any edge: state → IDLE, `rsp_valid`=0.
  - An in-flight load is abandoned with no response.
  - A store already written at its accepting edge stays written.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is an error.
  - No memory write occurs.
  - The unit goes IDLE → RESP.
  - `rsp_err`=1 and `rdata`=0 in the RESP cycle.
- `LSU_MISALIGN_TRAP_EN` undefined: `rsp_err` is constant 0. Offending low address bits are forced to zero (half → `addr[0]`=0, word → `addr[1:0]`=0), and the access proceeds normally.

## Test plan
- Reset then word store 0xDEADBEEF @0x10, word load @0x10 → `rsp_valid` 1 cycle after store acceptance; load `rdata`=0xDEADBEEF exactly 2 cycles after acceptance; `rsp_err`=0.
- Byte store 0x80 @0x13 over 0x11223344, then load signed byte @0x13 → 0xFFFFFF80; unsigned → 0x00000080; word load → 0x80223344.
- Half store 0xABCD @0x22 over 0, then signed half load @0x22 → 0xFFFFABCD; word load @0x20 → 0xABCD0000.
- Address wrap with ADDR_WIDTH=7: store word 0x5 @0x200, load @0x000 → 0x00000005. `req_valid` held high during LD_ACC/RESP is not accepted twice.
- Word load @0x21:
  - With the macro: `rsp_err`=1, `rdata`=0 at +1 cycle, and a subsequent load @0x20 is unchanged.
  - Without the macro: data from @0x20 is returned, `rsp_err`=0.
- `rstn` low in the LD_ACC cycle → no `rsp_valid`; `req_ready`=1 in the cycle after reset is released; a new load completes normally.

Source files
------------

// File: rtl/dm_lsu_if.sv
// Core <-> load/store unit request/response bundle.
// The core drives the request side (master); the LSU answers on the response side (slave).
interface dm_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, addr, wdata,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, addr, wdata,
    output req_ready, rsp_valid, rdata, rsp_err
  );
endinterface

// File: rtl/dm_lsu.sv
// Load/store unit with private word-organised data memory, byte-lane steering and extension.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them.
module dm_lsu #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic     clk,
  input  logic     rstn,
  dm_lsu_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LD_ACC, S_RESP} state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [31:0]           r_rdata;
  logic [31:0]           r_word;
  logic [1:0]            r_off;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [31:0]           r_mem [2**ADDR_WIDTH];

  logic                  w_accept;
  logic                  w_half;
  logic                  w_word;
  logic                  w_err;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_ld_data;
  logic [7:0]            w_lane_b;
  logic [15:0]           w_lane_h;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_unused_addr;

  assign w_accept      = bus.req_valid && r_req_ready && rstn;
  assign w_half        = (bus.req_size == 2'b01);
  assign w_word        = bus.req_size[1];
  assign w_idx         = bus.addr[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^bus.addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err = (w_half && bus.addr[0]) || (w_word && (bus.addr[1:0] != 2'b00));
`else
  assign w_err = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_off = bus.addr[1:0];
    if (w_word)      w_off = 2'b00;
    else if (w_half) w_off[0] = 1'b0;
  end

  // Replicate the store data so every lane sees its own byte; the enables pick the lanes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.wdata;
    if (!w_word && !w_half) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{bus.wdata[7:0]}};
    end else if (w_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{bus.wdata[15:0]}};
    end
  end

  assign w_lane_b = r_word[8*r_off +: 8];
  assign w_lane_h = r_off[1] ? r_word[31:16] : r_word[15:0];

  always_comb begin
    w_ld_data = r_word;
    case (r_size)
      2'b00:   w_ld_data = r_unsigned ? {24'd0, w_lane_b} : {{24{w_lane_b[7]}}, w_lane_b};
      2'b01:   w_ld_data = r_unsigned ? {16'd0, w_lane_h} : {{16{w_lane_h[15]}}, w_lane_h};
      default: w_ld_data = r_word;
    endcase
  end

  // NOTE: the memory array and request capture registers carry no reset; only control is reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_word     <= r_mem[w_idx];
      r_off      <= w_off;
      r_size     <= bus.req_size;
      r_unsigned <= bus.req_unsigned;
      if (bus.req_we && !w_err) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (bus.req_we || w_err) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rdata     <= 32'd0;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= S_LD_ACC;
            end
          end
        end
        S_LD_ACC: begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rdata     <= w_ld_data;
          r_rsp_err   <= 1'b0;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rdata     = r_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: directed scenarios plus random traffic against a byte-array model.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_dm_lsu;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mdl [512];

  dm_lsu_if bus ();

  dm_lsu #(.ADDR_WIDTH(7)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed little-endian memory model; memory wraps every 512 bytes.
  function automatic void model_access(input logic we, input logic [1:0] size, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic err, output logic [31:0] data);
    int     n;
    int     a;
    longint v;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a    = int'(addr % 32'd512);
    err  = 1'b0;
    data = 32'd0;
    if (a % n != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      err = 1'b1;
      return;
`else
      a = a - (a % n);
`endif
    end
    if (we) begin
      for (int i = 0; i < n; i++) mdl[a + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(mdl[a + i]) << (8 * i));
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      data = v[31:0];
    end
  endfunction

  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_data;
    model_access(we, size, uns, addr, wdata, exp_err, exp_data);
    got = 32'hx;
    @(negedge clk);
    check("ready_idle", bus.req_ready, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.addr         = addr;
    bus.wdata        = wdata;
    @(negedge clk);
    if (we || exp_err) begin
      check("rsp_valid_n1", bus.rsp_valid, 32'd1);
      check("rdata_n1", bus.rdata, exp_data);
      check("rsp_err_n1", bus.rsp_err, exp_err);
      got = bus.rdata;
    end else begin
      check("ldacc_rsp_valid", bus.rsp_valid, 32'd0);
      check("ldacc_ready", bus.req_ready, 32'd0);
    end
    // Keep the request asserted with scrambled fields: none of it may be taken.
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.addr         = $urandom;
    bus.wdata        = $urandom;
    if (!(we || exp_err)) begin
      @(negedge clk);
      check("rsp_valid_n2", bus.rsp_valid, 32'd1);
      check("rdata_n2", bus.rdata, exp_data);
      check("rsp_err_n2", bus.rsp_err, exp_err);
      got = bus.rdata;
    end
    @(negedge clk);
    check("rsp_pulse_end", bus.rsp_valid, 32'd0);
    check("ready_back", bus.req_ready, 32'd1);
    check("rdata_hold", bus.rdata, exp_data);
    check("rsp_err_hold", bus.rsp_err, exp_err);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] g;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.addr         = 32'd0;
    bus.wdata        = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.req_ready, 32'd1);
    check("rst_rsp_valid", bus.rsp_valid, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_rsp_err", bus.rsp_err, 32'd0);

    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, g);
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, g);
    check("tp_word", g, 32'hDEADBEEF);

    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, g);
    do_op(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, g);
    do_op(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, g);
    check("tp_byte_s", g, 32'hFFFFFF80);
    do_op(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, g);
    check("tp_byte_u", g, 32'h00000080);
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, g);
    check("tp_byte_word", g, 32'h80223344);

    do_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h00000000, g);
    do_op(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000ABCD, g);
    do_op(1'b0, 2'd1, 1'b0, 32'h22, 32'd0, g);
    check("tp_half_s", g, 32'hFFFFABCD);
    do_op(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, g);
    check("tp_half_word", g, 32'hABCD0000);

    do_op(1'b1, 2'd2, 1'b0, 32'h200, 32'h00000005, g);
    do_op(1'b0, 2'd2, 1'b0, 32'h000, 32'd0, g);
    check("tp_wrap", g, 32'h00000005);

    do_op(1'b0, 2'd2, 1'b0, 32'h21, 32'd0, g);
`ifdef LSU_MISALIGN_TRAP_EN
    check("tp_mis_rdata", g, 32'h00000000);
    do_op(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, g);
    check("tp_mis_after", g, 32'hABCD0000);
`else
    check("tp_mis_align", g, 32'hABCD0000);
`endif

    // Reset asserted while a load is in LD_ACC: no response may follow.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.addr      = 32'h10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rstn          = 1'b0;
    @(negedge clk);
    check("rst_ld_rsp_valid", bus.rsp_valid, 32'd0);
    check("rst_ld_rdata", bus.rdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_ld_ready", bus.req_ready, 32'd1);
    check("rst_ld_no_rsp", bus.rsp_valid, 32'd0);
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, g);
    check("rst_ld_reload", g, 32'h80223344);

    for (int w = 0; w < 128; w++) do_op(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, g);
    for (int k = 0; k < 160; k++) begin
      do_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
